regfile_port_ctrl: RTL and testbench
====================================

// Module: regfile_port_ctrl
// PURPOSE
//  Access controller driving the 7x15 two-read/one-write register file: issues operand reads,
//  registers the operands and commits writeback results. Tracks pending destination registers
//  in a scoreboard and stalls issue on RAW/WAW hazards. Sits between decode and execute.
// PARAMETERS
//  DW     15  register data width
//  AW     3   register address width
//  NREGS  7   implemented registers 0..6; address 7 is unimplemented
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   issue request valid
//  in_ready   out  1   issue accepted this cycle when in_valid & in_ready
//  in_rs1     in   AW  source register 1
//  in_rs2     in   AW  source register 2
//  in_rd      in   AW  destination register
//  in_rd_en   in   1   instruction writes in_rd
//  out_valid  out  1   operand bundle valid
//  out_ready  in   1   downstream accepts bundle
//  out_op1    out  DW  operand 1
//  out_op2    out  DW  operand 2
//  out_rd     out  AW  destination passed through
//  out_rd_en  out  1   destination enable passed through
//  wb_valid   in   1   writeback valid, always accepted, no ready
//  wb_addr    in   AW  writeback register
//  wb_data    in   DW  writeback data
//  rf_ra1     out  AW  register file read address 1 (= in_rs1, combinational)
//  rf_ra2     out  AW  register file read address 2 (= in_rs2, combinational)
//  rf_rd1     in   DW  register file read data 1 (combinational read)
//  rf_rd2     in   DW  register file read data 2
//  rf_wa      out  AW  register file write address (= wb_addr)
//  rf_wd      out  DW  register file write data (= wb_data)
//  rf_we      out  1   = wb_valid & (wb_addr != 7); file writes on rising edge
//  sb_busy    out  NREGS  scoreboard pending-write bits
// BEHAVIOUR
//  - Reset: out_valid=0, out_op1/out_op2=0, out_rd=0, out_rd_en=0, sb_busy=0; async assert, sync-safe release.
//  - hazard = busy[rs1] | busy[rs2] | (in_rd_en & busy[rd]); register 7 never busy.
//  - in_ready = !hazard & (!out_valid | out_ready). Issue = in_valid & in_ready.
//  - Latency 1: on issue edge, out_op1/out_op2 <= rf_rd1/rf_rd2 (forced 0 for address 7),
//    out_rd/out_rd_en <= in_rd/in_rd_en, out_valid <= 1.
//  - out_valid & out_ready & no issue -> out_valid <= 0; out_valid & !out_ready -> bundle held stable.
//  - Scoreboard: issue with in_rd_en & rd!=7 sets busy[rd]; wb_valid & wb_addr!=7 clears busy[wb_addr].
//    Set and clear on same register same edge: set wins. Writeback to a non-busy register:
//    file written, busy unchanged.
//  - Read of a register written the same cycle (non-busy case) returns the old value.
//  - wb_addr==7: rf_we=0, write dropped, no scoreboard effect.
//  - Mid-operation reset clears scoreboard and output stage; later writebacks still write the file.
// CONFIGURATION
//  BYPASS_EN defined: a source whose busy bit is set but matches wb_addr with wb_valid this cycle
//  is not a hazard; operand taken from wb_data; in_rd busy-with-matching-wb also not a hazard.
//  BYPASS_EN undefined: any busy source/destination stalls until the edge after the writeback.
// STRUCTURE
//  Shared include regfile_defs.vh: REG_DW=15, REG_AW=3, REG_N=7, REG_INVALID=3'd7.
//  Sub-module regfile_scoreboard: busy vector, set/clear ports, hazard lookup for rs1/rs2/rd.
// TESTING
//  1 Reset pulse mid-stream -> out_valid=0, sb_busy=7'h00, in_ready=1 with out_ready=0.
//  2 wb r3=15'h1234, wb r0=15'h0005, issue rs1=3 rs2=0 -> next cycle out_op1=15'h1234, out_op2=15'h0005.
//  3 Issue rd=2 rd_en=1, then rs1=2 -> in_ready=0 until wb r2=15'h7ABC; without BYPASS_EN accept
//    one cycle after wb; with BYPASS_EN accept in wb cycle; both give out_op1=15'h7ABC.
//  4 out_ready=0, two issues -> second sees in_ready=0, bundle 1 held; out_ready=1 -> second issued next edge.
//  5 wb addr 7 data 15'h7FFF -> rf_we=0; issue rs1=7 -> out_op1=0; rd=7 rd_en=1 -> sb_busy unchanged.
//  6 Issue rd=4, assert rst_n=0 before wb -> sb_busy[4]=0, out_valid=0; issue rs1=4 accepted without stall.

Source files
------------

// File: rtl/regfile_port_ctrl_pkg.sv
// Shared constants for the register-file port controller.
// Register 7 is unimplemented: it never stalls, reads as zero, drops writes.
package regfile_port_ctrl_pkg;

    localparam int REG_DW = 15;
    localparam int REG_AW = 3;
    localparam int REG_N  = 7;

    localparam logic [REG_AW-1:0] REG_INVALID = 3'd7;

    function automatic logic is_impl(input logic [REG_AW-1:0] a);
        return a != REG_INVALID;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard with hazard lookup for rs1/rs2/rd.
// With BYPASS_EN, a busy register retiring this cycle is not a hazard.
module regfile_scoreboard
    import regfile_port_ctrl_pkg::*;
#(
    parameter int AW    = REG_AW,
    parameter int NREGS = REG_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [AW-1:0]    rd,
    input  logic             rd_en,
    output logic             byp1,
    output logic             byp2,
    output logic             hazard,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_nxt;
    logic             b1;
    logic             b2;
    logic             bd;
    logic             bypd;

    function automatic logic lookup(
        input logic [NREGS-1:0] v,
        input logic [AW-1:0]    a
    );
        logic r;
        r = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (a == AW'(i)) r = v[i];
        end
        return r;
    endfunction

    always_comb begin
        b1 = lookup(busy, rs1);
        b2 = lookup(busy, rs2);
        bd = lookup(busy, rd);
`ifdef BYPASS_EN
        byp1 = b1 & clr_en & (clr_addr == rs1);
        byp2 = b2 & clr_en & (clr_addr == rs2);
        bypd = bd & clr_en & (clr_addr == rd);
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
        bypd = 1'b0;
`endif
        hazard = (b1 & ~byp1) | (b2 & ~byp2)
               | (rd_en & bd & ~bypd);
    end

    // Set is applied after clear so a same-edge collision leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NREGS; i++) begin
            if (clr_en && clr_addr == AW'(i)) busy_nxt[i] = 1'b0;
            if (set_en && set_addr == AW'(i)) busy_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Operand read / writeback controller for the 7x15 2R1W register file.
// Optional BYPASS_EN forwards same-cycle writeback data to busy sources.
module regfile_port_ctrl
    import regfile_port_ctrl_pkg::*;
#(
    parameter int DW    = REG_DW,
    parameter int AW    = REG_AW,
    parameter int NREGS = REG_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_rs1,
    input  logic [AW-1:0]    in_rs2,
    input  logic [AW-1:0]    in_rd,
    input  logic             in_rd_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_op1,
    output logic [DW-1:0]    out_op2,
    output logic [AW-1:0]    out_rd,
    output logic             out_rd_en,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_addr,
    input  logic [DW-1:0]    wb_data,
    output logic [AW-1:0]    rf_ra1,
    output logic [AW-1:0]    rf_ra2,
    input  logic [DW-1:0]    rf_rd1,
    input  logic [DW-1:0]    rf_rd2,
    output logic [AW-1:0]    rf_wa,
    output logic [DW-1:0]    rf_wd,
    output logic             rf_we,
    output logic [NREGS-1:0] sb_busy
);

    logic          hazard;
    logic          byp1;
    logic          byp2;
    logic          issue;
    logic          wb_we;
    logic [DW-1:0] op1_nxt;
    logic [DW-1:0] op2_nxt;

    assign rf_ra1 = in_rs1;
    assign rf_ra2 = in_rs2;
    assign rf_wa  = wb_addr;
    assign rf_wd  = wb_data;
    assign wb_we  = wb_valid & is_impl(wb_addr);
    assign rf_we  = wb_we;

    assign in_ready = ~hazard & (~out_valid | out_ready);
    assign issue    = in_valid & in_ready;

    regfile_scoreboard #(
        .AW    (AW),
        .NREGS (NREGS)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue & in_rd_en & is_impl(in_rd)),
        .set_addr (in_rd),
        .clr_en   (wb_we),
        .clr_addr (wb_addr),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .rd       (in_rd),
        .rd_en    (in_rd_en),
        .byp1     (byp1),
        .byp2     (byp2),
        .hazard   (hazard),
        .busy     (sb_busy)
    );

    always_comb begin
        op1_nxt = rf_rd1;
        op2_nxt = rf_rd2;
        if (byp1)               op1_nxt = wb_data;
        if (byp2)               op2_nxt = wb_data;
        if (!is_impl(in_rs1))   op1_nxt = '0;
        if (!is_impl(in_rs2))   op2_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_rd_en <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_op1   <= op1_nxt;
            out_op2   <= op2_nxt;
            out_rd    <= in_rd;
            out_rd_en <= in_rd_en;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Scoreboard bench for regfile_port_ctrl with a behavioural register file.
// Build with BYPASS_EN defined to exercise the forwarding variant.
module tb_regfile_port_ctrl;

`ifdef BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [14:0] op1;
        logic [14:0] op2;
        logic [2:0]  rd;
        logic        rd_en;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_rd_en;
    logic [2:0]  in_rs1, in_rs2, in_rd;
    logic        out_valid, out_ready, out_rd_en;
    logic [14:0] out_op1, out_op2;
    logic [2:0]  out_rd;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [14:0] wb_data;
    logic [2:0]  rf_ra1, rf_ra2, rf_wa;
    logic [14:0] rf_rd1, rf_rd2, rf_wd;
    logic        rf_we;
    logic [6:0]  sb_busy;

    logic [14:0] rf    [0:6];
    logic [14:0] model [0:6];
    logic [6:0]  mbusy;
    bit          exp_valid;
    exp_t        q[$];
    int          npass;
    int          ntotal;

    always #5 clk = ~clk;

    regfile_port_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_rd_en  (in_rd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op1   (out_op1),
        .out_op2   (out_op2),
        .out_rd    (out_rd),
        .out_rd_en (out_rd_en),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rf_ra1    (rf_ra1),
        .rf_ra2    (rf_ra2),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .rf_we     (rf_we),
        .sb_busy   (sb_busy)
    );

    // Address 7 returns junk so the controller's zero forcing is visible.
    assign rf_rd1 = (rf_ra1 == 3'd7) ? 15'h2AAA : rf[rf_ra1];
    assign rf_rd2 = (rf_ra2 == 3'd7) ? 15'h2AAA : rf[rf_ra2];

    always @(posedge clk) begin
        if (rf_we && rf_wa != 3'd7) rf[rf_wa] <= rf_wd;
    end

    function automatic logic [14:0] expop(input logic [2:0] a);
        if (a == 3'd7) return 15'h0;
        if (BYP && wb_valid && wb_addr == a && mbusy[a]) return wb_data;
        return model[a];
    endfunction

    // One clock: records issue/consume/writeback effects in the models.
    task automatic tick();
        bit   hs;
        bit   wbw;
        exp_t e;
        hs  = in_valid && in_ready;
        wbw = wb_valid && wb_addr != 3'd7;
        e.op1   = expop(in_rs1);
        e.op2   = expop(in_rs2);
        e.rd    = in_rd;
        e.rd_en = in_rd_en;
        @(posedge clk);
        if (exp_valid && out_ready) begin
            if (q.size() > 0) void'(q.pop_front());
            exp_valid = 1'b0;
        end
        if (hs) begin
            q.push_back(e);
            exp_valid = 1'b1;
        end
        if (wbw) begin
            mbusy[wb_addr] = 1'b0;
            model[wb_addr] = wb_data;
        end
        if (hs && in_rd_en && in_rd != 3'd7) mbusy[in_rd] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        ntotal++;
        if (out_valid !== 1'b0 || out_op1 !== 15'h0 || out_op2 !== 15'h0)
            $display("FAIL reset_out: valid=%b op1=%h op2=%h want 0 0 0",
                     out_valid, out_op1, out_op2);
        else npass++;
        ntotal++;
        if (out_rd !== 3'd0 || out_rd_en !== 1'b0)
            $display("FAIL reset_rd: rd=%0d en=%b want 0 0", out_rd, out_rd_en);
        else npass++;
        ntotal++;
        if (sb_busy !== 7'h00 || in_ready !== 1'b1)
            $display("FAIL reset_sb: busy=%h rdy=%b want 00 1", sb_busy, in_ready);
        else npass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 15'h1234;
        #1;
        ntotal++;
        if (rf_we !== 1'b1)
            $display("FAIL read_we: rf_we=%b want 1", rf_we);
        else npass++;
        tick();
        wb_addr = 3'd0; wb_data = 15'h0005;
        tick();
        wb_valid = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_rs1 = 3'd3; in_rs2 = 3'd0;
        in_rd = 3'd1; in_rd_en = 1'b0;
        #1;
        ntotal++;
        if (in_ready !== 1'b1)
            $display("FAIL read_rdy: in_ready=%b want 1", in_ready);
        else npass++;
        tick();
        in_valid = 1'b0;
        #1;
        ntotal++;
        if (q.size() == 0 || out_valid !== 1'b1 || out_op1 !== q[0].op1 ||
            out_op2 !== q[0].op2 || out_rd !== q[0].rd || out_rd_en !== q[0].rd_en)
            $display("FAIL read_bundle: v=%b op1=%h op2=%h want op1=%h op2=%h",
                     out_valid, out_op1, out_op2, q[0].op1, q[0].op2);
        else npass++;
        ntotal++;
        if (out_op1 !== 15'h1234 || out_op2 !== 15'h0005)
            $display("FAIL read_const: op1=%h op2=%h want 1234 0005", out_op1, out_op2);
        else npass++;
        tick();
    endtask

    task automatic test_raw();
        in_valid = 1'b1; in_rs1 = 3'd0; in_rs2 = 3'd0;
        in_rd = 3'd2; in_rd_en = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        ntotal++;
        if (sb_busy !== mbusy || sb_busy !== 7'h04)
            $display("FAIL raw_set: busy=%h want %h", sb_busy, mbusy);
        else npass++;
        tick();
        in_valid = 1'b1; in_rs1 = 3'd2; in_rs2 = 3'd1; in_rd_en = 1'b0;
        #1;
        ntotal++;
        if (in_ready !== 1'b0)
            $display("FAIL raw_stall: in_ready=%b want 0", in_ready);
        else npass++;
        tick();
        in_rs1 = 3'd0; in_rs2 = 3'd0; in_rd = 3'd2; in_rd_en = 1'b1;
        #1;
        ntotal++;
        if (in_ready !== 1'b0)
            $display("FAIL waw_stall: in_ready=%b want 0", in_ready);
        else npass++;
        in_rs1 = 3'd2; in_rs2 = 3'd1; in_rd_en = 1'b0;
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 15'h7ABC;
        #1;
        ntotal++;
        if (in_ready !== BYP)
            $display("FAIL raw_wbcyc: in_ready=%b want %b", in_ready, BYP);
        else npass++;
        tick();
        wb_valid = 1'b0;
`ifndef BYPASS_EN
        #1;
        ntotal++;
        if (in_ready !== 1'b1)
            $display("FAIL raw_after: in_ready=%b want 1", in_ready);
        else npass++;
        tick();
`endif
        in_valid = 1'b0;
        #1;
        ntotal++;
        if (q.size() == 0 || out_valid !== 1'b1 || out_op1 !== q[0].op1 ||
            out_op2 !== q[0].op2 || out_rd !== q[0].rd || out_rd_en !== q[0].rd_en)
            $display("FAIL raw_bundle: v=%b op1=%h op2=%h want op1=%h op2=%h",
                     out_valid, out_op1, out_op2, q[0].op1, q[0].op2);
        else npass++;
        ntotal++;
        if (out_op1 !== 15'h7ABC || sb_busy !== 7'h00)
            $display("FAIL raw_const: op1=%h busy=%h want 7abc 00", out_op1, sb_busy);
        else npass++;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_rs1 = 3'd3; in_rs2 = 3'd3;
        in_rd = 3'd5; in_rd_en = 1'b0;
        tick();
        in_rs1 = 3'd0; in_rs2 = 3'd3; in_rd = 3'd6;
        for (int i = 0; i < 2; i++) begin
            #1;
            ntotal++;
            if (in_ready !== 1'b0 || q.size() == 0 || out_valid !== 1'b1 ||
                out_op1 !== q[0].op1 || out_op2 !== q[0].op2 || out_rd !== q[0].rd)
                $display("FAIL b2b_hold%0d: rdy=%b v=%b op1=%h rd=%0d want 0 1 %h %0d",
                         i, in_ready, out_valid, out_op1, out_rd, q[0].op1, q[0].rd);
            else npass++;
            if (i == 0) tick();
        end
        out_ready = 1'b1;
        #1;
        ntotal++;
        if (in_ready !== 1'b1)
            $display("FAIL b2b_rdy: in_ready=%b want 1", in_ready);
        else npass++;
        tick();
        in_valid = 1'b0;
        #1;
        ntotal++;
        if (q.size() != 1 || out_valid !== 1'b1 || out_op1 !== q[0].op1 ||
            out_op2 !== q[0].op2 || out_rd !== q[0].rd || out_rd_en !== q[0].rd_en)
            $display("FAIL b2b_second: v=%b op1=%h op2=%h rd=%0d want %h %h %0d",
                     out_valid, out_op1, out_op2, out_rd, q[0].op1, q[0].op2, q[0].rd);
        else npass++;
        tick();
        #1;
        ntotal++;
        if (out_valid !== 1'b0)
            $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
        else npass++;
    endtask

    task automatic test_reg7();
        wb_valid = 1'b1; wb_addr = 3'd7; wb_data = 15'h7FFF;
        #1;
        ntotal++;
        if (rf_we !== 1'b0)
            $display("FAIL r7_we: rf_we=%b want 0", rf_we);
        else npass++;
        tick();
        wb_valid = 1'b0;
        in_valid = 1'b1; in_rs1 = 3'd7; in_rs2 = 3'd3;
        in_rd = 3'd7; in_rd_en = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        ntotal++;
        if (q.size() == 0 || out_valid !== 1'b1 || out_op1 !== q[0].op1 ||
            out_op2 !== q[0].op2 || out_op1 !== 15'h0 || sb_busy !== mbusy)
            $display("FAIL r7_bundle: op1=%h op2=%h busy=%h want 0 %h %h",
                     out_op1, out_op2, sb_busy, q[0].op2, mbusy);
        else npass++;
        tick();
        wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 15'h0666;
        in_valid = 1'b1; in_rs1 = 3'd6; in_rs2 = 3'd6;
        in_rd = 3'd6; in_rd_en = 1'b1;
        tick();
        wb_valid = 1'b0;
        in_valid = 1'b0;
        #1;
        ntotal++;
        if (q.size() == 0 || out_op1 !== q[0].op1 || out_op1 !== 15'h0 ||
            sb_busy !== mbusy || sb_busy[6] !== 1'b1)
            $display("FAIL same_cyc: op1=%h busy=%h want %h %h",
                     out_op1, sb_busy, q[0].op1, mbusy);
        else npass++;
        tick();
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        #1;
        ntotal++;
        if (sb_busy !== mbusy || sb_busy !== 7'h00)
            $display("FAIL r6_clear: busy=%h want %h", sb_busy, mbusy);
        else npass++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_rs1 = 3'd0; in_rs2 = 3'd0;
        in_rd = 3'd4; in_rd_en = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        ntotal++;
        if (sb_busy !== 7'h10 || out_valid !== 1'b1)
            $display("FAIL mid_pre: busy=%h v=%b want 10 1", sb_busy, out_valid);
        else npass++;
        rst_n = 1'b0;
        #1;
        ntotal++;
        if (out_valid !== 1'b0 || sb_busy !== 7'h00 || in_ready !== 1'b1)
            $display("FAIL mid_rst: v=%b busy=%h rdy=%b want 0 00 1",
                     out_valid, sb_busy, in_ready);
        else npass++;
        q.delete();
        exp_valid = 1'b0;
        mbusy = '0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_rs1 = 3'd4; in_rs2 = 3'd3; in_rd_en = 1'b0;
        #1;
        ntotal++;
        if (in_ready !== 1'b1)
            $display("FAIL mid_rdy: in_ready=%b want 1", in_ready);
        else npass++;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 15'h0444;
        tick();
        wb_valid = 1'b0;
        in_valid = 1'b1; in_rs1 = 3'd4; in_rs2 = 3'd4;
        tick();
        in_valid = 1'b0;
        #1;
        ntotal++;
        if (q.size() == 0 || out_valid !== 1'b1 || out_op1 !== q[0].op1 ||
            out_op2 !== q[0].op2 || out_op1 !== 15'h0444)
            $display("FAIL mid_wb: v=%b op1=%h op2=%h want 0444 %h",
                     out_valid, out_op1, out_op2, q[0].op2);
        else npass++;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        npass = 0;
        ntotal = 0;
        mbusy = '0;
        exp_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rf[i] = '0;
            model[i] = '0;
        end
        in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0;
        in_rd = '0; in_rd_en = 1'b0;
        out_ready = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        test_reset();
        test_read();
        test_raw();
        test_back_to_back();
        test_reg7();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
